// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - game scene controller with key-edge decode, battle return scene and frame-timed fade
module scene_sequencer #(
    parameter int          KEY_W           = 16,
    parameter logic [7:0]  START_KEY       = 8'h28,
    parameter logic [7:0]  ESC_KEY         = 8'h29,
    parameter int          FRAMES_PER_STEP = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [KEY_W-1:0] keycode,
    input  logic             vs,
    input  logic             door_hit,
    input  logic             encounter,
    input  logic             battle_over,
    output logic             intro,
    output logic             map,
    output logic             enterECEB,
    output logic             battle,
    output logic [3:0]       fade,
    output logic             busy,
    output logic             scene_changed
);

    localparam int         NKEYS  = KEY_W / 8;
    localparam logic [7:0] FPS_M1 = 8'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {S_INTRO, S_MAP, S_ECEB, S_BATTLE} scene_t;
    typedef enum logic [1:0] {T_IDLE, T_OUT, T_IN} xfer_t;

    xfer_t            state_q, state_d;
    scene_t           scene_q, scene_d, ret_q, ret_d, target_q, target_d;
    logic [3:0]       fade_q, fade_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             chg_q, chg_d;
    logic [KEY_W-1:0] key_q;
    logic             vs_q;

    logic   tick, esc_press, start_press, trig;
    scene_t trig_scene;

    // Empty slots (8'h00) never count as a key, so a zero code always reports absent.
    function automatic logic has_key(input logic [KEY_W-1:0] kc, input logic [7:0] k);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (kc[8*i +: 8] == k) hit = 1'b1;
        end
        return hit && (k != 8'h00);
    endfunction

    assign tick        = vs_q && !vs;
    assign esc_press   = has_key(keycode, ESC_KEY) && !has_key(key_q, ESC_KEY);
    assign start_press = has_key(keycode, START_KEY) && !has_key(key_q, START_KEY);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= T_IDLE;
            scene_q  <= S_INTRO;
            ret_q    <= S_MAP;
            target_q <= S_MAP;
            fade_q   <= 4'd15;
            cnt_q    <= 8'd0;
            chg_q    <= 1'b0;
            key_q    <= '0;
            vs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            scene_q  <= scene_d;
            ret_q    <= ret_d;
            target_q <= target_d;
            fade_q   <= fade_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
            key_q    <= keycode;
            vs_q     <= vs;
        end
    end

    always_comb begin
        state_d    = state_q;
        scene_d    = scene_q;
        ret_d      = ret_q;
        target_d   = target_q;
        fade_d     = fade_q;
        cnt_d      = cnt_q;
        chg_d      = 1'b0;
        trig       = 1'b0;
        trig_scene = scene_q;
        case (state_q)
            T_IDLE: begin
                if (scene_q != S_INTRO && esc_press) begin
                    trig = 1'b1; trig_scene = S_INTRO;
                end else begin
                    case (scene_q)
                        S_INTRO: if (start_press) begin trig = 1'b1; trig_scene = S_MAP; end
                        S_MAP: begin
                            if (door_hit) begin trig = 1'b1; trig_scene = S_ECEB; end
                            else if (encounter) begin
                                trig = 1'b1; trig_scene = S_BATTLE; ret_d = S_MAP;
                            end
                        end
                        S_ECEB: begin
                            if (door_hit) begin trig = 1'b1; trig_scene = S_MAP; end
                            else if (encounter) begin
                                trig = 1'b1; trig_scene = S_BATTLE; ret_d = S_ECEB;
                            end
                        end
                        S_BATTLE: if (battle_over) begin trig = 1'b1; trig_scene = ret_q; end
                    endcase
                end
                if (trig) begin
                    target_d = trig_scene;
                    cnt_d    = 8'd0;
                    state_d  = T_OUT;
                end
            end
            T_OUT: if (tick) begin
                if (cnt_q == FPS_M1) begin
                    cnt_d  = 8'd0;
                    fade_d = fade_q - 4'd1;
                    // Scene swaps while the screen is fully black.
                    if (fade_q == 4'd1) begin
                        scene_d = target_q;
                        chg_d   = 1'b1;
                        state_d = T_IN;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            T_IN: if (tick) begin
                if (cnt_q == FPS_M1) begin
                    cnt_d  = 8'd0;
                    fade_d = fade_q + 4'd1;
                    if (fade_q == 4'd14) state_d = T_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_comb begin
        intro         = (scene_q == S_INTRO);
        map           = (scene_q == S_MAP);
        enterECEB     = (scene_q == S_ECEB);
        battle        = (scene_q == S_BATTLE);
        fade          = fade_q;
        busy          = (state_q != T_IDLE);
        scene_changed = chg_q;
    end

endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - scoreboard bench for scene_sequencer with FRAMES_PER_STEP=2
module tb_scene_sequencer;

    localparam logic [3:0] SC_INTRO = 4'b1000, SC_MAP = 4'b0100, SC_ECEB = 4'b0010, SC_BATTLE = 4'b0001;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] keycode = 16'h0000;
    logic        vs = 1'b1;
    logic        door_hit = 1'b0, encounter = 1'b0, battle_over = 1'b0;
    logic        intro, map, enterECEB, battle, busy, scene_changed;
    logic [3:0]  fade;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [3:0] exp_q[$];

    scene_sequencer #(.KEY_W(16), .START_KEY(8'h28), .ESC_KEY(8'h29), .FRAMES_PER_STEP(2)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .vs(vs),
        .door_hit(door_hit), .encounter(encounter), .battle_over(battle_over),
        .intro(intro), .map(map), .enterECEB(enterECEB), .battle(battle),
        .fade(fade), .busy(busy), .scene_changed(scene_changed)
    );

    always #5 Clk = ~Clk;

    // Advance one cycle, sample #1 after the edge, and retire a scoreboard entry on each scene_changed pulse.
    task automatic step();
        logic [3:0] exp_s;
        @(posedge Clk);
        #1;
        if (scene_changed) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_scene_change got=%b expected=no_pulse", {intro, map, enterECEB, battle});
            end else begin
                exp_s = exp_q.pop_front();
                if ({intro, map, enterECEB, battle} !== exp_s) begin
                    errors++;
                    $display("FAIL scene_on_change got=%b expected=%b", {intro, map, enterECEB, battle}, exp_s);
                end
            end
        end
    endtask

    task automatic tick();
        vs = 1'b0;
        step();
        vs = 1'b1;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [15:0] kc, input logic d, input logic e, input logic b);
        keycode = kc; door_hit = d; encounter = e; battle_over = b;
        step();
        keycode = 16'h0000; door_hit = 1'b0; encounter = 1'b0; battle_over = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(); step();
        Reset = 1'b0;
        step();
        checks++;
        if ({intro, map, enterECEB, battle, fade, busy, scene_changed} !== {SC_INTRO, 4'd15, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%b_%0d_%b_%b expected=1000_15_0_0",
                     {intro, map, enterECEB, battle}, fade, busy, scene_changed);
        end
    endtask

    task automatic test_start_key();
        pulses = 0;
        exp_q.push_back(SC_MAP);
        keycode = 16'h0028;
        step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b expected=1", busy); end
        step(); step();
        keycode = 16'h0000;
        ticks(29);
        checks++;
        if (pulses !== 0 || fade !== 4'd1 || intro !== 1'b1) begin
            errors++;
            $display("FAIL start_tick29 got=pulses%0d_fade%0d_intro%b expected=pulses0_fade1_intro1", pulses, fade, intro);
        end
        tick();
        checks++;
        if (pulses !== 1 || fade !== 4'd0 || map !== 1'b1) begin
            errors++;
            $display("FAIL start_tick30 got=pulses%0d_fade%0d_map%b expected=pulses1_fade0_map1", pulses, fade, map);
        end
        ticks(29);
        checks++;
        if (busy !== 1'b1 || fade !== 4'd14) begin
            errors++;
            $display("FAIL start_tick59 got=busy%b_fade%0d expected=busy1_fade14", busy, fade);
        end
        tick();
        ticks(3);
        checks++;
        if ({intro, map, enterECEB, battle} !== SC_MAP || fade !== 4'd15 || busy !== 1'b0 || pulses !== 1) begin
            errors++;
            $display("FAIL start_done got=%b_fade%0d_busy%b_pulses%0d expected=0100_fade15_busy0_pulses1",
                     {intro, map, enterECEB, battle}, fade, busy, pulses);
        end
    endtask

    task automatic test_door_priority();
        exp_q.push_back(SC_ECEB);
        drive(16'h0000, 1'b1, 1'b1, 1'b0);
        ticks(60);
        checks++;
        if (enterECEB !== 1'b1 || battle !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL door_priority got=eceb%b_battle%b_busy%b expected=eceb1_battle0_busy0", enterECEB, battle, busy);
        end
    endtask

    task automatic test_battle_return();
        exp_q.push_back(SC_BATTLE);
        drive(16'h0000, 1'b0, 1'b1, 1'b0);
        ticks(60);
        exp_q.push_back(SC_ECEB);
        drive(16'h0000, 1'b0, 1'b0, 1'b1);
        ticks(60);
        checks++;
        if ({intro, map, enterECEB, battle} !== SC_ECEB) begin
            errors++;
            $display("FAIL return_eceb got=%b expected=%b", {intro, map, enterECEB, battle}, SC_ECEB);
        end
        exp_q.push_back(SC_MAP);
        drive(16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(60);
        exp_q.push_back(SC_BATTLE);
        drive(16'h0000, 1'b0, 1'b1, 1'b0);
        ticks(60);
        exp_q.push_back(SC_MAP);
        drive(16'h0000, 1'b0, 1'b0, 1'b1);
        ticks(60);
        checks++;
        if ({intro, map, enterECEB, battle} !== SC_MAP) begin
            errors++;
            $display("FAIL return_map got=%b expected=%b", {intro, map, enterECEB, battle}, SC_MAP);
        end
    endtask

    task automatic test_esc_during_fade();
        pulses = 0;
        exp_q.push_back(SC_ECEB);
        drive(16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(12);
        checks++;
        if (fade !== 4'd9) begin errors++; $display("FAIL esc_fade_level got=%0d expected=9", fade); end
        keycode = 16'h2900;
        ticks(48);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if ({intro, map, enterECEB, battle} !== SC_ECEB || busy !== 1'b0 || pulses !== 1) begin
            errors++;
            $display("FAIL esc_ignored got=%b_busy%b_pulses%0d expected=0010_busy0_pulses1",
                     {intro, map, enterECEB, battle}, busy, pulses);
        end
        keycode = 16'h0000;
        step();
    endtask

    task automatic test_esc_upper_slot();
        exp_q.push_back(SC_MAP);
        drive(16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(60);
        exp_q.push_back(SC_INTRO);
        drive(16'h2904, 1'b0, 1'b0, 1'b0);
        ticks(60);
        checks++;
        if ({intro, map, enterECEB, battle} !== SC_INTRO) begin
            errors++;
            $display("FAIL esc_upper got=%b expected=%b", {intro, map, enterECEB, battle}, SC_INTRO);
        end
        exp_q.push_back(SC_MAP);
        drive(16'h2829, 1'b0, 1'b0, 1'b0);
        ticks(60);
        checks++;
        if ({intro, map, enterECEB, battle} !== SC_MAP) begin
            errors++;
            $display("FAIL esc_in_intro got=%b expected=%b", {intro, map, enterECEB, battle}, SC_MAP);
        end
    endtask

    task automatic test_reset_mid_fade();
        exp_q.push_back(SC_ECEB);
        drive(16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(38);
        checks++;
        if (fade !== 4'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_fade_level got=fade%0d_busy%b expected=fade4_busy1", fade, busy);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if ({intro, map, enterECEB, battle, fade, busy, scene_changed} !== {SC_INTRO, 4'd15, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got=%b_%0d_%b_%b expected=1000_15_0_0",
                     {intro, map, enterECEB, battle}, fade, busy, scene_changed);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(SC_MAP);
        drive(16'h0028, 1'b0, 1'b0, 1'b0);
        ticks(60);
        exp_q.push_back(SC_ECEB);
        drive(16'h0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL back_to_back_busy got=%b expected=1", busy); end
        ticks(60);
        checks++;
        if (exp_q.size() !== 0 || enterECEB !== 1'b1) begin
            errors++;
            $display("FAIL scoreboard_drain got=pending%0d_eceb%b expected=pending0_eceb1", exp_q.size(), enterECEB);
        end
    endtask

    initial begin
        test_reset();
        test_start_key();
        test_door_priority();
        test_battle_return();
        test_esc_during_fade();
        test_esc_upper_slot();
        test_reset_mid_fade();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
